layer_train_driver: RTL and testbench

- Training sequencer that drives one learning neuron layer: presents stored samples and targets, pulses learn, captures the layer output and scores the error.
- Sits between host/testbench sample loading and a layer instance (N_IN inputs, N_OUT neurons). It is the source of in/valid/learn/expected_out and the sink of out.
- Runs a programmed number of epochs over a programmed number of samples, then reports done and the last epoch's error.

---
 rtl/layer_train_driver_pkg.sv | 15 +
 rtl/layer_train_driver_if.sv | 23 ++
 rtl/layer_train_driver_abs_diff_sum.sv | 19 +
 rtl/layer_train_driver.sv | 155 +++++++++++++++
 tb/tb_layer_train_driver.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/layer_train_driver_pkg.sv
// Shared types for the layer training sequencer: unit-interval sample values and FSM states.
package layer_train_driver_pkg;
  localparam int Z2O_W = 8;

  typedef logic [Z2O_W-1:0] zero2one_t;
  typedef logic [Z2O_W-1:0] frac_t;

  typedef enum logic [2:0] {
    IDLE,
    PRESENT,
    WAIT,
    SCORE,
    DONE
  } train_state_t;
endpackage

// File: rtl/layer_train_driver_if.sv
// Sequencer-to-layer bus: master is the training driver, slave is the neuron layer.
interface layer_train_driver_if
  import layer_train_driver_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int N_OUT = 23
);
  logic                   layer_valid;
  logic                   layer_learn;
  zero2one_t [N_IN-1:0]   layer_in;
  zero2one_t [N_OUT-1:0]  layer_expected_out;
  zero2one_t [N_OUT-1:0]  layer_out;

  modport master (
    output layer_valid, layer_learn, layer_in, layer_expected_out,
    input  layer_out
  );

  modport slave (
    input  layer_valid, layer_learn, layer_in, layer_expected_out,
    output layer_out
  );
endinterface

// File: rtl/layer_train_driver_abs_diff_sum.sv
// Combinational unsigned sum of |a[k]-b[k]| over N lanes; output width never overflows.
module abs_diff_sum
  import layer_train_driver_pkg::*;
#(
  parameter int N = 23
) (
  input  zero2one_t [N-1:0]               a,
  input  zero2one_t [N-1:0]               b,
  output logic [Z2O_W+$clog2(N)-1:0]      sum
);
  localparam int SW = Z2O_W + $clog2(N);

  always_comb begin
    sum = '0;
    for (int k = 0; k < N; k++) begin
      sum = sum + SW'((a[k] > b[k]) ? (a[k] - b[k]) : (b[k] - a[k]));
    end
  end
endmodule

// File: rtl/layer_train_driver.sv
// Epoch/sample training sequencer for one neuron layer; one sample per LAT+2 cycles.
// Optional LAYER_TRAIN_EARLY_STOP_EN adds err_thresh and ends the run once an epoch error is <= it.
module layer_train_driver
  import layer_train_driver_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int N_OUT = 23,
  parameter int DEPTH = 64,
  parameter int LAT   = 1,
  parameter int ERR_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  zero2one_t [N_IN-1:0]       wr_in,
  input  zero2one_t [N_OUT-1:0]      wr_target,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     num_samples,
  input  logic [15:0]                num_epochs,
`ifdef LAYER_TRAIN_EARLY_STOP_EN
  input  logic [ERR_W-1:0]           err_thresh,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [ERR_W-1:0]           epoch_err,
  output logic [15:0]                epoch_cnt,
  layer_train_driver_if.master       lyr
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = Z2O_W + $clog2(N_OUT);
  localparam int WW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef struct packed {
    zero2one_t [N_OUT-1:0] target;
    zero2one_t [N_IN-1:0]  in;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          rd;
  train_state_t    state;
  logic [AW-1:0]   idx;
  logic [AW-1:0]   rd_idx;
  logic [AW:0]     n_samp;
  logic [15:0]     n_epoch;
  logic [WW-1:0]   wait_cnt;
  logic [ERR_W-1:0] acc;
  logic [ERR_W:0]  acc_sum;
  logic [ERR_W-1:0] acc_next;
  logic [SW-1:0]   sample_err;
  logic            last_sample;
  logic            stop_now;

  always_ff @(posedge clock) begin
    if (state == IDLE && wr_en) mem[wr_addr] <= '{target: wr_target, in: wr_in};
  end

  abs_diff_sum #(.N(N_OUT)) u_err (
    .a   (lyr.layer_out),
    .b   (lyr.layer_expected_out),
    .sum (sample_err)
  );

  assign last_sample = ({1'b0, idx} == (n_samp - 1'b1));
  // Entry fetched for the PRESENT that the current cycle is about to enter.
  assign rd_idx   = (state == SCORE && !last_sample) ? idx + 1'b1 : '0;
  assign rd       = mem[rd_idx];
  assign acc_sum  = {1'b0, acc} + (ERR_W+1)'(sample_err);
  assign acc_next = acc_sum[ERR_W] ? '1 : acc_sum[ERR_W-1:0];

`ifdef LAYER_TRAIN_EARLY_STOP_EN
  assign stop_now = (epoch_cnt + 16'd1 == n_epoch) || (acc_next <= err_thresh);
`else
  assign stop_now = (epoch_cnt + 16'd1 == n_epoch);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      idx                    <= '0;
      n_samp                 <= '0;
      n_epoch                <= '0;
      wait_cnt               <= '0;
      acc                    <= '0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      epoch_err              <= '0;
      epoch_cnt              <= '0;
      lyr.layer_valid        <= 1'b0;
      lyr.layer_learn        <= 1'b0;
      lyr.layer_in           <= '0;
      lyr.layer_expected_out <= '0;
    end else begin
      done            <= 1'b0;
      lyr.layer_valid <= 1'b0;
      lyr.layer_learn <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            epoch_cnt <= '0;
            if (num_samples == '0 || num_epochs == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              n_samp                 <= num_samples;
              n_epoch                <= num_epochs;
              idx                    <= '0;
              acc                    <= '0;
              busy                   <= 1'b1;
              lyr.layer_valid        <= 1'b1;
              lyr.layer_learn        <= 1'b1;
              lyr.layer_in           <= rd.in;
              lyr.layer_expected_out <= rd.target;
              state                  <= PRESENT;
            end
          end
        end
        PRESENT: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == WW'(LAT - 1)) state <= SCORE;
          else wait_cnt <= wait_cnt + 1'b1;
        end
        SCORE: begin
          if (!last_sample) begin
            acc   <= acc_next;
            idx   <= idx + 1'b1;
            state <= PRESENT;
          end else begin
            epoch_err <= acc_next;
            acc       <= '0;
            idx       <= '0;
            epoch_cnt <= epoch_cnt + 16'd1;
            state     <= stop_now ? DONE : PRESENT;
          end
          if (!last_sample || !stop_now) begin
            lyr.layer_valid        <= 1'b1;
            lyr.layer_learn        <= 1'b1;
            lyr.layer_in           <= rd.in;
            lyr.layer_expected_out <= rd.target;
          end else begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_train_driver.sv
// Directed bench for layer_train_driver with a programmable stub layer (echo / zero / late-echo / constant).
module tb_layer_train_driver;
  import layer_train_driver_pkg::*;

  localparam int N_IN  = 16;
  localparam int N_OUT = 23;
  localparam int DEPTH = 64;
  localparam int LAT   = 1;
  localparam int ERR_W = 32;
  localparam int AW    = $clog2(DEPTH);

  typedef zero2one_t [N_IN-1:0]  in_vec_t;
  typedef zero2one_t [N_OUT-1:0] out_vec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  in_vec_t       wr_in;
  out_vec_t      wr_target;
  logic          start;
  logic [AW:0]   num_samples;
  logic [15:0]   num_epochs;
  logic          busy;
  logic          done;
  logic [ERR_W-1:0] epoch_err;
  logic [15:0]   epoch_cnt;
`ifdef LAYER_TRAIN_EARLY_STOP_EN
  logic [ERR_W-1:0] err_thresh;
`endif

  layer_train_driver_if #(.N_IN(N_IN), .N_OUT(N_OUT)) lyr ();

  layer_train_driver #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH), .LAT(LAT), .ERR_W(ERR_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_in       (wr_in),
    .wr_target   (wr_target),
    .start       (start),
    .num_samples (num_samples),
    .num_epochs  (num_epochs),
`ifdef LAYER_TRAIN_EARLY_STOP_EN
    .err_thresh  (err_thresh),
`endif
    .busy        (busy),
    .done        (done),
    .epoch_err   (epoch_err),
    .epoch_cnt   (epoch_cnt),
    .lyr         (lyr.master)
  );

  always #5 clock = ~clock;

  // Stub layer: 0 echo target, 1 all zero, 2 zero in epoch 0 then echo, 3 constant fixed_val.
  int        mode = 0;
  zero2one_t fixed_val = '0;
  always_comb begin
    lyr.layer_out = '0;
    for (int k = 0; k < N_OUT; k++) begin
      case (mode)
        0:       lyr.layer_out[k] = lyr.layer_expected_out[k];
        1:       lyr.layer_out[k] = '0;
        2:       lyr.layer_out[k] = (epoch_cnt >= 16'd1) ? lyr.layer_expected_out[k] : '0;
        default: lyr.layer_out[k] = fixed_val;
      endcase
    end
  end

  int cyc = 0;
  int valid_cnt = 0;
  int done_cnt = 0;
  int v_cyc = 0;
  int d_cyc = 0;
  logic [ERR_W-1:0] err1 = '0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (lyr.layer_valid) begin valid_cnt++; v_cyc = cyc; end
    if (done) begin done_cnt++; d_cyc = cyc; end
    if (busy && epoch_cnt == 16'd1) err1 = epoch_err;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic in_vec_t mk_in(input int base);
    in_vec_t v;
    for (int k = 0; k < N_IN; k++) v[k] = zero2one_t'(base + k);
    return v;
  endfunction

  function automatic out_vec_t mk_const(input zero2one_t c);
    out_vec_t v;
    for (int k = 0; k < N_OUT; k++) v[k] = c;
    return v;
  endfunction

  task automatic wr(input int addr, input in_vec_t iv, input out_vec_t tv);
    @(negedge clock);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_in = iv; wr_target = tv;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  // Returns at the negedge after start is sampled (PRESENT for a normal run).
  task automatic kick(input int ns, input int ne);
    @(negedge clock);
    start = 1'b1; num_samples = (AW+1)'(ns); num_epochs = 16'(ne);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!done && n < max_cyc) begin
      @(negedge clock); #1;
      n++;
    end
    if (!done) chk({tag, "_timeout"}, 64'(0), 64'(1));
  endtask

  int vb, db;
  out_vec_t ramp;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_in = '0; wr_target = '0;
    start = 1'b0; num_samples = '0; num_epochs = '0;
`ifdef LAYER_TRAIN_EARLY_STOP_EN
    err_thresh = '0;
`endif
    #12;
    chk("rst_busy",  64'(busy), 64'(0));
    chk("rst_done",  64'(done), 64'(0));
    chk("rst_err",   64'(epoch_err), 64'(0));
    chk("rst_cnt",   64'(epoch_cnt), 64'(0));
    chk("rst_valid", 64'(lyr.layer_valid), 64'(0));
    chk("rst_learn", 64'(lyr.layer_learn), 64'(0));
    chk("rst_in",    64'(lyr.layer_in == '0), 64'(1));
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) wr(i, mk_in(i * 16 + 1), mk_const(8'hFF));

    // Single sample, one epoch, layer echoes target.
    mode = 0; vb = valid_cnt; db = done_cnt;
    kick(1, 1); #1;
    chk("p_valid",  64'(lyr.layer_valid), 64'(1));
    chk("p_learn",  64'(lyr.layer_learn), 64'(1));
    chk("p_busy",   64'(busy), 64'(1));
    chk("p_in",     64'(lyr.layer_in == mk_in(1)), 64'(1));
    chk("p_tgt",    64'(lyr.layer_expected_out == mk_const(8'hFF)), 64'(1));
    @(negedge clock); #1;
    chk("w_valid",  64'(lyr.layer_valid), 64'(0));
    chk("w_hold",   64'(lyr.layer_in == mk_in(1)), 64'(1));
    wait_done("t1", 20);
    chk("t1_lat",   64'(d_cyc - v_cyc), 64'(3));
    chk("t1_busy",  64'(busy), 64'(0));
    chk("t1_err",   64'(epoch_err), 64'(0));
    chk("t1_cnt",   64'(epoch_cnt), 64'(1));
    chk("t1_nvld",  64'(valid_cnt - vb), 64'(1));

    // Four samples, two epochs, zero output; write to entry 0 mid-run must be ignored.
    mode = 1; vb = valid_cnt; db = done_cnt;
    kick(4, 2);
    repeat (3) @(negedge clock);
    wr_en = 1'b1; wr_addr = '0; wr_in = '0; wr_target = '0;
    @(negedge clock);
    wr_en = 1'b0;
    wait_done("t2", 100);
    chk("t2_err1",  64'(err1), 64'(23460));
    chk("t2_err",   64'(epoch_err), 64'(23460));
    chk("t2_cnt",   64'(epoch_cnt), 64'(2));
    chk("t2_nvld",  64'(valid_cnt - vb), 64'(8));
    repeat (3) @(negedge clock); #1;
    chk("t2_ndone", 64'(done_cnt - db), 64'(1));
    chk("t2_hold",  64'(epoch_err), 64'(23460));
    kick(1, 1);
    wait_done("t2b", 20);
    chk("t2_mem",   64'(epoch_err), 64'(5865));

    // Zero epochs / zero samples complete immediately without presenting.
    vb = valid_cnt; db = done_cnt;
    kick(4, 0); #1;
    chk("z_done",   64'(done), 64'(1));
    chk("z_busy",   64'(busy), 64'(0));
    chk("z_cnt",    64'(epoch_cnt), 64'(0));
    kick(0, 3); #1;
    chk("z2_done",  64'(done), 64'(1));
    repeat (3) @(negedge clock); #1;
    chk("z_nvld",   64'(valid_cnt - vb), 64'(0));
    chk("z_ndone",  64'(done_cnt - db), 64'(2));

    // Reset during WAIT of epoch 0.
    mode = 1; db = done_cnt;
    kick(4, 1);
    @(negedge clock); #1;
    chk("r_busy_pre", 64'(busy), 64'(1));
    #1 reset = 1'b1;
    #1;
    chk("r_busy",   64'(busy), 64'(0));
    chk("r_valid",  64'(lyr.layer_valid), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("r_ndone",  64'(done_cnt - db), 64'(0));
    mode = 0;
    kick(1, 1);
    wait_done("r", 20);
    chk("r_err",    64'(epoch_err), 64'(0));
    chk("r_cnt",    64'(epoch_cnt), 64'(1));

    // Two-sided absolute difference: targets 10*k against constant 100.
    for (int k = 0; k < N_OUT; k++) ramp[k] = zero2one_t'(10 * k);
    wr(0, mk_in(5), ramp);
    mode = 3; fixed_val = 8'd100;
    kick(1, 1);
    wait_done("ad", 20);
    chk("ad_err",   64'(epoch_err), 64'(1330));

`ifdef LAYER_TRAIN_EARLY_STOP_EN
    err_thresh = '0; mode = 2;
    kick(1, 10);
    wait_done("es", 200);
    chk("es_cnt",   64'(epoch_cnt), 64'(2));
    chk("es_err",   64'(epoch_err), 64'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
